gost89_ofb_byte_stream: RTL and testbench
=========================================

// Module: gost89_ofb_byte_stream
// PURPOSE
//  Upstream/downstream adapter for the GOST 28147-89 OFB encrypt/decrypt core.
//  - Packs an 8-bit valid/ready byte stream into 64-bit blocks and drives the core's load_data/load_IV/in.
//  - Waits out core busy, then unpacks the 64-bit result back into a byte stream.
//  - The same block serves both the encrypt and decrypt core instances. Key is wired straight to the core.
// PARAMETERS
//  BUSY_TMO  4  max cycles from core_load_data to core_busy high before err is raised
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   asynchronous active-low reset
//  iv_valid       in   1   new IV offered
//  iv             in   64  IV value
//  iv_ready       out  1   IV accepted when iv_valid&iv_ready
//  s_valid        in   1   input byte valid
//  s_data         in   8   input byte; first byte of block = bits [63:56]
//  s_last         in   1   last byte of message (may close a partial block)
//  s_ready        out  1   input byte accepted when s_valid&s_ready
//  m_valid        out  1   output byte valid
//  m_data         out  8   output byte
//  m_last         out  1   last output byte of message
//  m_ready        in   1   downstream accepts byte
//  core_reset     out  1   active-high reset to core
//  core_load_data out  1   one-cycle load pulse to core
//  core_load_IV   out  1   one-cycle IV load pulse, coincident with core_load_data
//  core_in        out  64  block to core
//  core_IV        out  64  IV to core
//  core_out       in   64  core result
//  core_busy      in   1   core processing
//  err            out  1   sticky: core never went busy; cleared only by reset_n
// BEHAVIOUR
//  Reset values: all outputs 0 except core_reset=1.
//  - core_reset stays 1 while reset_n=0 and for 1 cycle after release.
//  FSM states: IDLE -> FILL -> LOAD -> ACK -> WAIT -> DRAIN -> IDLE.
//  - IDLE/FILL: s_ready=1. Each accepted byte shifts into buf[63:0] MSB-first and increments cnt (3b+wrap).
//  - 8th byte or s_last: go to LOAD. Partial block: remaining low bytes are zero, nbytes=cnt+1.
//  - LOAD (1 cycle): core_load_data=1, core_in=buf; core_load_IV=iv_pend, then iv_pend clears.
//  - ACK: wait for core_busy=1. If BUSY_TMO cycles elapse without it, set err and return to IDLE (block dropped).
//  - WAIT: wait for core_busy=0, then capture core_out into obuf and go to DRAIN.
//  - DRAIN: m_valid=1, m_data=obuf[63:56]; shift obuf left 8 on m_valid&m_ready.
//    Emits nbytes bytes; m_last=1 on the final byte when the block was closed by s_last.
//    Leaves DRAIN on that final handshake.
//  - Bytes beyond nbytes are never emitted (OFB truncation).
//  - m_valid must not drop and m_data must not change while m_ready=0.
//  IV:
//  - iv_ready=1 only in IDLE with cnt=0. Accept: core_IV<=iv, iv_pend<=1.
//  - If iv_valid and s_valid arrive together in IDLE, the IV is taken first; that byte is accepted the same cycle.
//  - No IV after reset: first block issues core_load_IV=0, so the core uses its own state.
//  Mid-operation reset_n: FSM to IDLE, buffers, cnt, iv_pend and err cleared, core reset.
//  - A partial output block is discarded.
//  s_last with cnt=7 is an ordinary full block with m_last set.
//  Back-to-back messages: none; s_ready=0 from LOAD until the DRAIN exit.
//  - Minimum per-block latency: 8 in + 1 LOAD + core time + 8 out.
// CONFIGURATION
//  GOST89_BSTREAM_CNT_EN defined:
//  - Adds output port blk_cnt [31:0], reset 0.
//  - +1 on each LOAD cycle; wraps 2^32-1 -> 0; cleared by reset_n only.
//  Not defined: no port, no counter logic; all other behaviour identical.
// STRUCTURE
//  Package gost89_pkg: block width 64, byte count 8, FSM state enum, BUSY_TMO default.
//  - The same package is used by the OFB cores.
//  Sub-module gost89_byte_unpack: obuf shift register + DRAIN handshake + m_last/nbytes logic.
//  Pack side, FSM and IV latch live in the top.
// TESTING (bench core model: out = in ^ 64'hA5A5A5A5A5A5A5A5, busy high 32 cycles, 1 cycle after load)
//  1. IV 64'hd5a8a608f4f115b4, then 8 bytes 0x00 with s_last on the 8th:
//     - core_load_IV=1 and core_load_data=1 in the same cycle, core_in=0.
//     - 8 bytes 0xA5 out, m_last on the 8th.
//  2. Bytes 01 23 45 67 89 ab cd ef with no IV, m_ready toggled 1/0:
//     - core_load_IV=0, core_in=64'h0123456789abcdef.
//     - Output a4 86 e0 c2 2c 0e 68 4a, m_data held stable while stalled.
//  3. 3 bytes 3b 58 34 with s_last:
//     - core_in=64'h3b58340000000000.
//     - Exactly 3 bytes 9e fd 91 out, m_last on 91, then IDLE.
//  4. reset_n low 1 cycle during WAIT (12 cycles after load):
//     - All outputs at reset values, core_reset 1 for 1 cycle after release.
//     - No output bytes; next 8-byte block processes normally.
//  5. Core model never raises busy:
//     - err=1 exactly BUSY_TMO cycles after core_load_data.
//     - FSM back in IDLE, s_ready=1, err stays 1 until reset_n.
//  6. GOST89_BSTREAM_CNT_EN: blk_cnt preset 32'hFFFFFFFF by force, one block -> blk_cnt=0.
//     - Build without the macro compiles with no blk_cnt port.

Source files
------------

// File: rtl/gost89_pkg.sv
// -----------------------------------------------------------------------------
// gost89_pkg
// Shared definitions for the GOST 28147-89 OFB cores and their byte-stream
// adapter: block geometry, adapter FSM state encoding and the default
// busy-acknowledge timeout.
// -----------------------------------------------------------------------------
package gost89_pkg;

    localparam int BLK_W        = 64;   // cipher block width in bits
    localparam int BLK_BYTES    = 8;    // bytes per block
    localparam int BUSY_TMO_DEF = 4;    // cycles allowed for core_busy to rise

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ACK   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } bs_state_t;

endpackage

// File: rtl/gost89_byte_unpack.sv
// -----------------------------------------------------------------------------
// gost89_byte_unpack
// Holds one 64-bit core result and emits it MSB byte first on a valid/ready
// byte stream. Only the first i_nbytes bytes are emitted; o_last marks the
// final byte when the block closed its message.
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   i_load         capture i_block / i_nbytes / i_last (one cycle)
//   i_block        64-bit core result
//   i_nbytes       number of valid bytes in the block (1..8)
//   i_last         block ends the message
//   i_ready        downstream ready
//   o_valid        byte valid (held until accepted)
//   o_data         current byte (obuf[63:56])
//   o_last         final byte of message
//   o_done         final byte handshake of this block
// -----------------------------------------------------------------------------
module gost89_byte_unpack
    import gost89_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [BLK_W-1:0] i_block,
    input  logic [3:0]       i_nbytes,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_last,
    output logic             o_done
);

    logic [BLK_W-1:0] r_obuf;
    logic [3:0]       r_left;
    logic             r_last;
    logic             r_active;

    logic             w_fire;
    logic             w_final;

    assign w_fire  = r_active & i_ready;
    assign w_final = (r_left == 4'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_obuf   <= '0;
            r_left   <= '0;
            r_last   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_obuf   <= i_block;
            r_left   <= i_nbytes;
            r_last   <= i_last;
            r_active <= (i_nbytes != 4'd0);
        end else if (w_fire) begin
            // Bytes past nbytes are shifted out of view but never presented.
            r_obuf <= {r_obuf[BLK_W-9:0], 8'h00};
            r_left <= r_left - 4'd1;
            if (w_final) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_valid = r_active;
    assign o_data  = r_obuf[BLK_W-1 -: 8];
    assign o_last  = r_active & r_last & w_final;
    assign o_done  = w_fire & w_final;

endmodule

// File: rtl/gost89_ofb_byte_stream.sv
// -----------------------------------------------------------------------------
// gost89_ofb_byte_stream
// Byte-stream adapter for a GOST 28147-89 OFB encrypt or decrypt core. Packs
// input bytes MSB-first into 64-bit blocks, loads them (optionally with a new
// IV) into the core, waits for the core to finish and streams the result back
// out, truncated to the number of input bytes in the block.
//
// Optional build macro: GOST89_BSTREAM_CNT_EN adds a 32-bit blk_cnt output
// counting block loads (wrapping, cleared only by reset_n).
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   iv_valid/iv/iv_ready          IV offer, accepted only in IDLE with no bytes
//   s_valid/s_data/s_last/s_ready input byte stream
//   m_valid/m_data/m_last/m_ready output byte stream
//   core_reset                    active-high core reset (reset + 1 cycle)
//   core_load_data/core_load_IV   one-cycle load pulses to the core
//   core_in/core_IV               block and IV to the core
//   core_out/core_busy            core result and busy flag
//   err                           sticky: core failed to go busy after a load
//   blk_cnt                       (GOST89_BSTREAM_CNT_EN only) load counter
// -----------------------------------------------------------------------------
module gost89_ofb_byte_stream
    import gost89_pkg::*;
#(
    parameter int BUSY_TMO = BUSY_TMO_DEF
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             iv_valid,
    input  logic [BLK_W-1:0] iv,
    output logic             iv_ready,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             core_reset,
    output logic             core_load_data,
    output logic             core_load_IV,
    output logic [BLK_W-1:0] core_in,
    output logic [BLK_W-1:0] core_IV,
    input  logic [BLK_W-1:0] core_out,
    input  logic             core_busy,
    output logic             err
`ifdef GOST89_BSTREAM_CNT_EN
    ,
    output logic [31:0]      blk_cnt
`endif
);

    bs_state_t        r_state;
    logic [BLK_W-1:0] r_buf;
    logic [2:0]       r_cnt;
    logic [3:0]       r_nbytes;
    logic             r_msg_last;
    logic             r_iv_pend;
    logic [BLK_W-1:0] r_core_iv;
    logic             r_load_data;
    logic             r_load_iv;
    logic [7:0]       r_tmo;
    logic             r_err;
    logic             r_rst_q;
    logic             r_core_rst;

    logic             w_s_fire;
    logic             w_iv_fire;
    logic             w_unpack_load;
    logic             w_done;
    logic [5:0]       w_byte_lsb;

    // Nothing is accepted while the core itself is still held in reset.
    assign s_ready   = ((r_state == ST_IDLE) || (r_state == ST_FILL)) & ~r_core_rst;
    assign iv_ready  = (r_state == ST_IDLE) & (r_cnt == 3'd0) & ~r_core_rst;
    assign w_s_fire  = s_valid & s_ready;
    assign w_iv_fire = iv_valid & iv_ready;

    // Bit position of the byte slot selected by r_cnt (slot 0 = bits 63:56).
    assign w_byte_lsb = {3'd7 - r_cnt, 3'b000};

    assign w_unpack_load = (r_state == ST_WAIT) & ~core_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_nbytes    <= '0;
            r_msg_last  <= 1'b0;
            r_iv_pend   <= 1'b0;
            r_core_iv   <= '0;
            r_load_data <= 1'b0;
            r_load_iv   <= 1'b0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_rst_q     <= 1'b1;
            r_core_rst  <= 1'b1;
        end else begin
            // Two-stage release keeps core_reset high one full cycle after reset_n.
            r_rst_q     <= 1'b0;
            r_core_rst  <= r_rst_q;
            r_load_data <= 1'b0;
            r_load_iv   <= 1'b0;

            if (w_iv_fire) begin
                r_core_iv <= iv;
                r_iv_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_FILL: begin
                    if (w_s_fire) begin
                        // First byte clears the block so a short block is zero padded.
                        if (r_cnt == 3'd0) begin
                            r_buf <= {s_data, 56'h0};
                        end else begin
                            r_buf[w_byte_lsb +: 8] <= s_data;
                        end
                        if ((r_cnt == 3'd7) || s_last) begin
                            r_state     <= ST_LOAD;
                            r_cnt       <= 3'd0;
                            r_nbytes    <= {1'b0, r_cnt} + 4'd1;
                            r_msg_last  <= s_last;
                            r_load_data <= 1'b1;
                            // An IV taken in this same cycle still rides with this block.
                            r_load_iv   <= r_iv_pend | w_iv_fire;
                        end else begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_LOAD: begin
                    r_iv_pend <= 1'b0;
                    r_tmo     <= 8'd1;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    if (core_busy) begin
                        r_state <= ST_WAIT;
                    end else if (r_tmo >= 8'(BUSY_TMO - 1)) begin
                        // Core never started: drop the block, flag it, go idle.
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (!core_busy) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    gost89_byte_unpack u_unpack (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_unpack_load),
        .i_block  (core_out),
        .i_nbytes (r_nbytes),
        .i_last   (r_msg_last),
        .i_ready  (m_ready),
        .o_valid  (m_valid),
        .o_data   (m_data),
        .o_last   (m_last),
        .o_done   (w_done)
    );

    assign core_reset     = r_core_rst;
    assign core_load_data = r_load_data;
    assign core_load_IV   = r_load_iv;
    assign core_in        = r_buf;
    assign core_IV        = r_core_iv;
    assign err            = r_err;

`ifdef GOST89_BSTREAM_CNT_EN
    logic [31:0] r_blk_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_gost89_ofb_byte_stream.sv
// -----------------------------------------------------------------------------
// tb_gost89_ofb_byte_stream
// Directed bench for gost89_ofb_byte_stream with a simple core model
// (out = in ^ A5A5..., busy for 32 cycles starting one cycle after load).
// -----------------------------------------------------------------------------
module tb_gost89_ofb_byte_stream;

    localparam logic [63:0] KMASK = 64'hA5A5A5A5A5A5A5A5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        iv_valid = 1'b0;
    logic [63:0] iv = '0;
    logic        iv_ready;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        core_reset;
    logic        core_load_data;
    logic        core_load_IV;
    logic [63:0] core_in;
    logic [63:0] core_IV;
    logic [63:0] core_out = '0;
    logic        core_busy = 1'b0;
    logic        err;
`ifdef GOST89_BSTREAM_CNT_EN
    logic [31:0] blk_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic       model_dead = 1'b0;
    logic [5:0] bcnt = '0;

    gost89_ofb_byte_stream dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .iv_valid       (iv_valid),
        .iv             (iv),
        .iv_ready       (iv_ready),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .core_reset     (core_reset),
        .core_load_data (core_load_data),
        .core_load_IV   (core_load_IV),
        .core_in        (core_in),
        .core_IV        (core_IV),
        .core_out       (core_out),
        .core_busy      (core_busy),
        .err            (err)
`ifdef GOST89_BSTREAM_CNT_EN
        ,
        .blk_cnt        (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Core model
    always @(posedge clk) begin
        if (core_reset) begin
            core_busy <= 1'b0;
            bcnt      <= '0;
        end else if (core_load_data && !model_dead) begin
            core_out  <= core_in ^ KMASK;
            core_busy <= 1'b1;
            bcnt      <= 6'd31;
        end else if (bcnt != 6'd0) begin
            bcnt <= bcnt - 6'd1;
        end else begin
            core_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the accepting clock edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("s_ready_timeout", {63'h0, s_ready}, 64'h1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] blk, input int n, input logic l);
        for (int i = 0; i < n; i++) begin
            send_byte(blk[63-8*i -: 8], (l && (i == n - 1)));
        end
    endtask

    task automatic recv(input logic [63:0] exp, input int n, input logic lst, input logic stall);
        logic [63:0] e;
        e = exp;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!m_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk("m_valid_wait", {63'h0, m_valid}, 64'h1);
            if (stall) begin
                m_ready = 1'b0;
                chk("stall_pre_data", {56'h0, m_data}, {56'h0, e[63-8*i -: 8]});
                @(negedge clk);
                chk("stall_valid", {63'h0, m_valid}, 64'h1);
                chk("stall_data", {56'h0, m_data}, {56'h0, e[63-8*i -: 8]});
            end
            m_ready = 1'b1;
            chk("m_data", {56'h0, m_data}, {56'h0, e[63-8*i -: 8]});
            chk("m_last", {63'h0, m_last}, {63'h0, (lst && (i == n - 1))});
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("m_valid_after", {63'h0, m_valid}, 64'h0);
        chk("idle_s_ready", {63'h0, s_ready}, 64'h1);
    endtask

    task automatic wait_core_out_of_reset();
        int n;
        n = 0;
        while (core_reset && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int cnt_v;

        // Reset state
        @(negedge clk);
        chk("rst_core_reset", {63'h0, core_reset}, 64'h1);
        chk("rst_s_ready", {63'h0, s_ready}, 64'h0);
        chk("rst_iv_ready", {63'h0, iv_ready}, 64'h0);
        chk("rst_m_valid", {63'h0, m_valid}, 64'h0);
        chk("rst_load", {62'h0, core_load_data, core_load_IV}, 64'h0);
        chk("rst_core_in", core_in, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel1_core_reset", {63'h0, core_reset}, 64'h1);
        @(negedge clk);
        chk("rel2_core_reset", {63'h0, core_reset}, 64'h0);
        chk("rel2_s_ready", {63'h0, s_ready}, 64'h1);
`ifdef GOST89_BSTREAM_CNT_EN
        chk("rst_blk_cnt", {32'h0, blk_cnt}, 64'h0);
`endif

        // 1: IV then 8 zero bytes, last on 8th
        iv_valid = 1'b1;
        iv       = 64'hd5a8a608f4f115b4;
        chk("t1_iv_ready", {63'h0, iv_ready}, 64'h1);
        @(posedge clk);
        #1;
        iv_valid = 1'b0;
        chk("t1_core_IV", core_IV, 64'hd5a8a608f4f115b4);
        send_block(64'h0, 8, 1'b1);
        chk("t1_load_data", {63'h0, core_load_data}, 64'h1);
        chk("t1_load_IV", {63'h0, core_load_IV}, 64'h1);
        chk("t1_core_in", core_in, 64'h0);
        chk("t1_s_ready_load", {63'h0, s_ready}, 64'h0);
        recv(64'hA5A5A5A5A5A5A5A5, 8, 1'b1, 1'b0);

        // 2: no IV, stalled output
        send_block(64'h0123456789abcdef, 8, 1'b0);
        chk("t2_load_data", {63'h0, core_load_data}, 64'h1);
        chk("t2_load_IV", {63'h0, core_load_IV}, 64'h0);
        chk("t2_core_in", core_in, 64'h0123456789abcdef);
        recv(64'ha486e0c22c0e684a, 8, 1'b0, 1'b1);

        // 3: partial block of 3 bytes
        send_block(64'h3b58340000000000, 3, 1'b1);
        chk("t3_load_data", {63'h0, core_load_data}, 64'h1);
        chk("t3_core_in", core_in, 64'h3b58340000000000);
        recv(64'h9efd910000000000, 3, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("t3_no_extra", {63'h0, m_valid}, 64'h0);

        // 4: reset during WAIT
        send_block(64'h1122334455667788, 8, 1'b0);
        chk("t4_load_data", {63'h0, core_load_data}, 64'h1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_core_reset", {63'h0, core_reset}, 64'h1);
        chk("t4_rst_core_in", core_in, 64'h0);
        chk("t4_rst_core_IV", core_IV, 64'h0);
        chk("t4_rst_outs", {58'h0, s_ready, iv_ready, m_valid, m_last, core_load_data, err}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t4_rel1_core_reset", {63'h0, core_reset}, 64'h1);
        chk("t4_rel1_s_ready", {63'h0, s_ready}, 64'h0);
        @(negedge clk);
        chk("t4_rel2_core_reset", {63'h0, core_reset}, 64'h0);
        chk("t4_rel2_s_ready", {63'h0, s_ready}, 64'h1);
        cnt_v = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid) cnt_v++;
        end
        chk("t4_no_output", 64'(cnt_v), 64'h0);
        send_block(64'hf0e1d2c3b4a59687, 8, 1'b1);
        chk("t4_core_in", core_in, 64'hf0e1d2c3b4a59687);
        recv(64'h5544776611003322, 8, 1'b1, 1'b0);

        // 5: core never goes busy
        model_dead = 1'b1;
        send_block(64'h5a5a5a5a5a5a5a5a, 8, 1'b0);
        chk("t5_load_data", {63'h0, core_load_data}, 64'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_early", {63'h0, err}, 64'h0);
        @(posedge clk);
        #1;
        chk("t5_err_set", {63'h0, err}, 64'h1);
        chk("t5_s_ready", {63'h0, s_ready}, 64'h1);
        chk("t5_iv_ready", {63'h0, iv_ready}, 64'h1);
        repeat (10) @(negedge clk);
        chk("t5_err_sticky", {63'h0, err}, 64'h1);
        chk("t5_no_output", {63'h0, m_valid}, 64'h0);
        model_dead = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_err_cleared", {63'h0, err}, 64'h0);
        wait_core_out_of_reset();
        @(negedge clk);

`ifdef GOST89_BSTREAM_CNT_EN
        // 6: block counter wrap
        chk("t6_blk_cnt_rst", {32'h0, blk_cnt}, 64'h0);
        force dut.r_blk_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_blk_cnt;
        chk("t6_blk_cnt_preset", {32'h0, blk_cnt}, 64'h00000000FFFFFFFF);
        send_block(64'h0, 1, 1'b1);
        recv(64'hA500000000000000, 1, 1'b1, 1'b0);
        chk("t6_blk_cnt_wrap", {32'h0, blk_cnt}, 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
